fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controls the SPU instruction fetch stage. It owns the fetch PC, tracks which 64B line (16 instruction words) is resident in the instruction line buffer, and issues refill requests to local store on a miss. It also applies decode stalls and branch redirects, and tells fetch which of the two dual-issue slots hold valid instructions. It sits between the decode stage, the instruction line buffer and the local-store fill port.

Parameters:
PC_W, 8, width of the instruction-word index (256-word space)
LINE_WORDS, 16, 32-bit instructions per 64B line; power of 2, at least 2
CNT_W, 16, width of the saturating miss counter

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low; sampled on the clk rising edge
stall  in  1  decode stall; hold the current pair
branch_taken  in  1  one-cycle redirect pulse from decode/branch unit
branch_target  in  PC_W  word index of the redirect target
fill_ack  in  1  one-cycle pulse: requested line is now written into the line buffer
fetch_pc  out  PC_W  even word index of the pair to read (slot0=fetch_pc, slot1=fetch_pc+1)
slot_valid  out  2  bit0=slot0 valid, bit1=slot1 valid; 0 means the slot is NOP-filled
fill_req  out  1  line refill request, level
fill_addr  out  PC_W  line base address, fetch_pc & ~(LINE_WORDS-1)
busy  out  1  high while in S_IDLE or S_FILL
miss_count  out  CNT_W  number of fills issued, saturating

Behaviour:
- Reset (reset==0 at a clk edge) forces: state=S_IDLE, pc=0, tag=0, tag_valid=0, kill0=0, fill_req=0, fill_addr=0, miss_count=0. Combinational outputs follow: slot_valid=0, busy=1. Reset mid-fill abandons the fill; a late fill_ack is ignored.
- States and transitions:
  - S_IDLE: go to S_FILL unconditionally on the next cycle.
  - S_FILL: entry registers fill_req=1, fill_addr=line(pc), miss_count+1 (saturates at all-ones). fill_addr is held stable while fill_req=1. On fill_ack: tag<=fill_addr, tag_valid<=1, fill_req<=0, go to S_RUN.
  - S_RUN: hit = tag_valid && line(pc)==tag. On a miss, go to S_FILL next cycle; slot_valid=0 in that cycle.
- fill_ack outside S_FILL is ignored.
- Redirect during S_FILL: pc and kill0 update immediately, but the fill completes and the tag installs the old fill_addr. S_RUN then re-checks hit and refills if needed. No cancel path.
- slot_valid is combinational: S_RUN && hit gives {1, ~kill0}; all other cases give 0.
- fetch_pc = pc, registered.
- Priority each cycle, in S_RUN or S_FILL: branch_taken > stall > advance.
  - Branch: pc <= branch_target & ~1; kill0 <= branch_target[0]. An odd target invalidates slot0 on the first pair only.
  - Stall: pc and kill0 hold.
  - Advance (S_RUN, hit, !stall): pc <= pc+2 modulo 2^PC_W; kill0 <= 0.
- Branch latency: branch_taken at edge N puts the target pair on fetch_pc after edge N. If the target is resident, slot_valid is nonzero in that same cycle. The sequencer makes no further redirect decisions.
- Crossing a line boundary: pc+2 lands in a new line, which causes a miss, then a fill. Minimum penalty is 1 cycle plus fill latency.
- Wrap: pc 254 advances to 0. Line 0 misses unless it is already resident.
- Simultaneous branch_taken and fill_ack in S_FILL: both take effect; the next S_RUN cycle evaluates hit against the new pc.
- pc is always even; kill0 is the only odd-target state.

Decomposition:
- Shared package spu_fetch_pkg holds:
  - fetch_state_t enum {S_IDLE, S_FILL, S_RUN}
  - localparams LINE_WORDS and PC_W
  - NOP and LNOP encodings, so fetch fills invalid slots consistently
- A single flat module. The tag compare and the saturating counter are too small to justify sub-modules.

Test Plan:
- Reset low 2 cycles, then high; fill_ack 3 cycles later → fill_req=1, fill_addr=0, busy=1; after ack, slot_valid=2'b11, fetch_pc=0, miss_count=1.
- Run with stall=0 from pc=0, line 0 resident → fetch_pc 0,2,…,14. Next cycle slot_valid=0, then fill_req=1, fill_addr=16, miss_count=2.
- stall=1 for 3 cycles at fetch_pc=6 → fetch_pc stays 6 and slot_valid stays 11; the pc=8 pair appears 1 cycle after stall drops.
- branch_taken with target=9 while line 0 resident → fetch_pc=8, slot_valid=2'b10 for one cycle, then fetch_pc=10, slot_valid=11.
- branch_taken with target=40 during S_FILL for line 0 → the ack installs tag 0, then a miss, fill_addr=32, fetch_pc=40 after the second ack.
- Line 240 resident, advance from pc=254 → fetch_pc=0, miss, fill_addr=0. Also: hold fill_ack high after saturation to confirm miss_count holds at 16'hFFFF.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the SPU fetch sequencer: FSM states, geometry and
// the filler encodings used for NOP-filled dual-issue slots.
package spu_fetch_pkg;

    localparam int PC_W       = 8;
    localparam int LINE_WORDS = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } fetch_state_t;

    // Even-pipe and odd-pipe no-op encodings placed in invalid slots.
    localparam logic [31:0] NOP  = 32'h4020_0000;
    localparam logic [31:0] LNOP = 32'h0020_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decode / line-buffer / local-store fill signals around the fetch sequencer.
interface fetch_sequencer_if
    import spu_fetch_pkg::*;
#(
    parameter int PC_W  = spu_fetch_pkg::PC_W,
    parameter int CNT_W = spu_fetch_pkg::CNT_W
);
    logic              stall;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_target;
    logic              fill_ack;
    logic [PC_W-1:0]   fetch_pc;
    logic [1:0]        slot_valid;
    logic              fill_req;
    logic [PC_W-1:0]   fill_addr;
    logic              busy;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output stall, branch_taken, branch_target, fill_ack,
        input  fetch_pc, slot_valid, fill_req, fill_addr, busy, miss_count
    );

    modport slave (
        input  stall, branch_taken, branch_target, fill_ack,
        output fetch_pc, slot_valid, fill_req, fill_addr, busy, miss_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// SPU fetch sequencer: owns the fetch PC, tracks the resident 64B line and
// issues local-store refills on a miss; applies stalls and branch redirects.
module fetch_sequencer
    import spu_fetch_pkg::*;
#(
    parameter int PC_W       = spu_fetch_pkg::PC_W,
    parameter int LINE_WORDS = spu_fetch_pkg::LINE_WORDS,
    parameter int CNT_W      = spu_fetch_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.slave    bus
);

    localparam logic [PC_W-1:0]  LINE_MASK = ~(PC_W'(LINE_WORDS - 1));
    localparam logic [PC_W-1:0]  EVEN_MASK = {{(PC_W-1){1'b1}}, 1'b0};
    localparam logic [PC_W-1:0]  PC_STEP   = {{(PC_W-2){1'b0}}, 2'b10};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              kill0_q, kill0_d;
    logic [PC_W-1:0]   tag_q, tag_d;
    logic              tag_valid_q, tag_valid_d;
    logic              fill_req_q, fill_req_d;
    logic [PC_W-1:0]   fill_addr_q, fill_addr_d;
    logic [CNT_W-1:0]  miss_count_q, miss_count_d;

    logic              hit_s;
    logic              steer_en_s;
    logic [CNT_W-1:0]  miss_inc_s;

    assign hit_s      = tag_valid_q && ((pc_q & LINE_MASK) == tag_q);
    assign steer_en_s = (state_q == S_RUN) || (state_q == S_FILL);
    assign miss_inc_s = (&miss_count_q) ? miss_count_q : (miss_count_q + CNT_ONE);

    // PC steering: branch beats stall beats advance; advance only on a hit.
    always_comb begin
        pc_d    = pc_q;
        kill0_d = kill0_q;
        if (steer_en_s) begin
            if (bus.branch_taken) begin
                pc_d    = bus.branch_target & EVEN_MASK;
                kill0_d = bus.branch_target[0];
            end else if (bus.stall) begin
                pc_d    = pc_q;
                kill0_d = kill0_q;
            end else if ((state_q == S_RUN) && hit_s) begin
                pc_d    = pc_q + PC_STEP;
                kill0_d = 1'b0;
            end else begin
                pc_d    = pc_q;
                kill0_d = kill0_q;
            end
        end else begin
            pc_d    = pc_q;
            kill0_d = kill0_q;
        end
    end

    // Line-buffer FSM; a fill targets the line of the PC being installed this edge.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        fill_req_d   = fill_req_q;
        fill_addr_d  = fill_addr_q;
        miss_count_d = miss_count_q;
        case (state_q)
            S_IDLE: begin
                state_d      = S_FILL;
                fill_req_d   = 1'b1;
                fill_addr_d  = pc_d & LINE_MASK;
                miss_count_d = miss_inc_s;
            end
            S_FILL: begin
                if (bus.fill_ack) begin
                    tag_d       = fill_addr_q;
                    tag_valid_d = 1'b1;
                    fill_req_d  = 1'b0;
                    state_d     = S_RUN;
                end else begin
                    state_d     = S_FILL;
                end
            end
            S_RUN: begin
                if (!hit_s) begin
                    state_d      = S_FILL;
                    fill_req_d   = 1'b1;
                    fill_addr_d  = pc_d & LINE_MASK;
                    miss_count_d = miss_inc_s;
                end else begin
                    state_d      = S_RUN;
                end
            end
            default: begin
                state_d    = S_IDLE;
                fill_req_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            kill0_q      <= 1'b0;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            fill_req_q   <= 1'b0;
            fill_addr_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill0_q      <= kill0_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            fill_req_q   <= fill_req_d;
            fill_addr_q  <= fill_addr_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.fetch_pc   = pc_q;
    assign bus.slot_valid = ((state_q == S_RUN) && hit_s) ? {1'b1, ~kill0_q} : 2'b00;
    assign bus.fill_req   = fill_req_q;
    assign bus.fill_addr  = fill_addr_q;
    assign bus.busy       = (state_q == S_IDLE) || (state_q == S_FILL);
    assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a behavioural model;
// a second instance with a 4-bit counter exercises miss_count saturation.
module tb_fetch_sequencer;
    import spu_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_W(8), .CNT_W(16)) bus ();
    fetch_sequencer_if #(.PC_W(8), .CNT_W(4))  bus2 ();

    assign bus2.stall         = bus.stall;
    assign bus2.branch_taken  = bus.branch_taken;
    assign bus2.branch_target = bus.branch_target;
    assign bus2.fill_ack      = bus.fill_ack;

    fetch_sequencer #(.PC_W(8), .LINE_WORDS(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    fetch_sequencer #(.PC_W(8), .LINE_WORDS(16), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2));

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: 0 = idle, 1 = waiting for a fill, 2 = running.
    int m_mode, m_pc, m_kill, m_tag, m_tv, m_freq, m_faddr, m_cnt;

    function automatic int line_of(input int p);
        return (p / 16) * 16;
    endfunction

    function automatic bit m_hit();
        return (m_mode == 2) && (m_tv != 0) && (line_of(m_pc) == m_tag);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit b, input int t, input bit a);
        int  npc;
        int  nk;
        bit  hit;
        if (!r) begin
            m_mode = 0; m_pc = 0; m_kill = 0; m_tag = 0; m_tv = 0;
            m_freq = 0; m_faddr = 0; m_cnt = 0;
            return;
        end
        hit = m_hit();
        npc = m_pc;
        nk  = m_kill;
        if (m_mode != 0) begin
            if (b) begin
                npc = t & 254;
                nk  = t & 1;
            end else if (!s && hit) begin
                npc = (m_pc + 2) % 256;
                nk  = 0;
            end
        end
        if (m_mode == 0 || (m_mode == 2 && !hit)) begin
            m_mode = 1; m_freq = 1; m_faddr = line_of(npc); m_cnt++;
        end else if (m_mode == 1 && a) begin
            m_tag = m_faddr; m_tv = 1; m_freq = 0; m_mode = 2;
        end
        m_pc   = npc;
        m_kill = nk;
    endtask

    task automatic check_all();
        int sv;
        sv = m_hit() ? (m_kill != 0 ? 2 : 3) : 0;
        chk("fetch_pc",   32'(bus.fetch_pc),   32'(m_pc));
        chk("slot_valid", 32'(bus.slot_valid), 32'(sv));
        chk("fill_req",   32'(bus.fill_req),   32'(m_freq));
        chk("fill_addr",  32'(bus.fill_addr),  32'(m_faddr));
        chk("busy",       32'(bus.busy),       32'(m_mode != 2));
        chk("miss_count", 32'(bus.miss_count), 32'(m_cnt > 65535 ? 65535 : m_cnt));
        chk("miss_sat4",  32'(bus2.miss_count), 32'(m_cnt > 15 ? 15 : m_cnt));
    endtask

    task automatic step(input bit r, input bit s, input bit b, input int t, input bit a);
        reset             = r;
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.branch_target = t[7:0];
        bus.fill_ack      = a;
        model_edge(r, s, b, t, a);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int t;
        reset = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = 8'd0; bus.fill_ack = 1'b0;
        @(negedge clk);

        // Reset, first fill of line 0, ack three cycles later.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        // Advance to 6, stall three cycles, resume.
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Odd target kills slot0 on the first pair only.
        step(1, 0, 1, 9, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Redirect during a fill: old line installs, then refill of line 32.
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 40, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        // Line 240 with simultaneous branch + ack, then wrap 254 -> 0.
        step(1, 0, 1, 240, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 250, 1);
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Reset mid-fill; a late ack must be ignored.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 0) t = int'($urandom_range(0, 255));
            else t = (m_tag + int'($urandom_range(0, 15))) % 256;
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 t,
                 (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
        end

        // Continuous line-hopping with fill_ack held high drives the 4-bit counter to saturation.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 0, 1, (i * 16) % 256, 1);
        chk("sat_hold", 32'(bus2.miss_count), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
